// File: rtl/line_buf_ctrl.sv
// rtl/line_buf_ctrl.sv - frame sequencer for a 3x3 line-buffer window generator
//
// Sequences one image frame through an external line_buf. The line_buf
// introduces WIN_LAT = LINE_LEN+3 cycles between a pixel entering and that
// pixel reaching the 3x3 window centre. This block accepts the frame, pads
// the line_buf for WIN_LAT-1 cycles so the last pixel reaches the centre,
// and reports the coordinates of every real pixel as it passes the centre.
//
// Optional feature macro: LINE_BUF_CTRL_BORDER_EN
//   defined   : border flags window centres on the frame edge
//   undefined : border is tied to 0 and no edge comparators exist
//
// Parameters
//   LINE_LEN   pixels per line (line_buf row depth)
//   NUM_LINES  lines per frame
//   CX_W/CY_W  widths of the cx/cy coordinate outputs
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      frame start request, honoured in IDLE only
//   in_valid   source offers a pixel this cycle
//   in_ready   pixel accepted into line_buf this cycle (decoded from state)
//   src_sel    line_buf input mux: 0 = source pixel, 1 = pad value (decoded)
//   busy       state is not IDLE
//   win_valid  window centre holds a real frame pixel
//   cx, cy     column/row of the window centre (0 when win_valid=0)
//   border     window centre lies on the frame edge
//   done       one-cycle end-of-frame pulse
//   err        one-cycle source-underrun pulse

module line_buf_ctrl #(
    parameter int LINE_LEN  = 640,
    parameter int NUM_LINES = 480,
    parameter int CX_W      = 10,
    parameter int CY_W      = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            src_sel,
    output logic            busy,
    output logic            win_valid,
    output logic [CX_W-1:0] cx,
    output logic [CY_W-1:0] cy,
    output logic            border,
    output logic            done,
    output logic            err
);

    localparam int WIN_LAT   = LINE_LEN + 3;
    localparam int FRAME_PIX = LINE_LEN * NUM_LINES;
    // lat_cnt runs continuously through RUN and FLUSH; its final FLUSH value
    localparam int LAST_CNT  = FRAME_PIX + WIN_LAT - 2;
    localparam int CNT_W     = $clog2(LAST_CNT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  lat_cnt;
    logic [CNT_W-1:0]  lat_cnt_nxt;
    logic              win_valid_nxt;
    logic              err_nxt;
    logic [CX_W-1:0]   cx_nxt;
    logic [CY_W-1:0]   cy_nxt;

    // The only two unregistered outputs: pure decodes of the state register
    assign in_ready = (state == RUN);
    assign src_sel  = (state != RUN);

    // Next-state and counter logic. In RUN and FLUSH, lat_cnt equals the
    // number of cycles spent since RUN was entered, which is also the index
    // of the pixel accepted in RUN.
    always_comb begin
        state_nxt   = state;
        lat_cnt_nxt = lat_cnt;
        err_nxt     = 1'b0;
        case (state)
            IDLE: begin
                lat_cnt_nxt = '0;
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!in_valid) begin
                    // Underrun aborts the frame; the partial frame is dropped
                    state_nxt   = IDLE;
                    err_nxt     = 1'b1;
                    lat_cnt_nxt = '0;
                end else begin
                    lat_cnt_nxt = lat_cnt + 1'b1;
                    if (lat_cnt == CNT_W'(FRAME_PIX - 1)) begin
                        state_nxt = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (lat_cnt == CNT_W'(LAST_CNT)) begin
                    state_nxt   = DONE;
                    lat_cnt_nxt = '0;
                end else begin
                    lat_cnt_nxt = lat_cnt + 1'b1;
                end
            end
            DONE: begin
                state_nxt   = IDLE;
                lat_cnt_nxt = '0;
            end
            default: begin
                state_nxt   = IDLE;
                lat_cnt_nxt = '0;
            end
        endcase
    end

    // Pixel 0 reaches the centre WIN_LAT cycles after it was accepted, so the
    // window becomes valid once lat_cnt reaches WIN_LAT-1 and stays valid
    // (pixels are contiguous) until the DONE cycle, the last valid cycle.
    always_comb begin
        win_valid_nxt = 1'b0;
        if (((state == RUN) && in_valid) || (state == FLUSH)) begin
            win_valid_nxt = (lat_cnt >= CNT_W'(WIN_LAT - 1));
        end
    end

    // Centre coordinates: restart at (0,0) on the first valid cycle, advance
    // in raster order afterwards, and read 0 whenever the window is invalid.
    always_comb begin
        cx_nxt = '0;
        cy_nxt = '0;
        if (win_valid_nxt && win_valid) begin
            if (cx == CX_W'(LINE_LEN - 1)) begin
                cx_nxt = '0;
                cy_nxt = (cy == CY_W'(NUM_LINES - 1)) ? cy : cy + 1'b1;
            end else begin
                cx_nxt = cx + 1'b1;
                cy_nxt = cy;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            busy      <= 1'b0;
            win_valid <= 1'b0;
            cx        <= '0;
            cy        <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            lat_cnt   <= lat_cnt_nxt;
            busy      <= (state_nxt != IDLE);
            win_valid <= win_valid_nxt;
            cx        <= cx_nxt;
            cy        <= cy_nxt;
            done      <= (state_nxt == DONE);
            err       <= err_nxt;
        end
    end

`ifdef LINE_BUF_CTRL_BORDER_EN
    logic border_nxt;

    // Evaluated on the next coordinates so border lines up with cx/cy
    always_comb begin
        border_nxt = 1'b0;
        if (win_valid_nxt) begin
            border_nxt = (cx_nxt == '0) ||
                         (cx_nxt == CX_W'(LINE_LEN - 1)) ||
                         (cy_nxt == '0) ||
                         (cy_nxt == CY_W'(NUM_LINES - 1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            border <= 1'b0;
        end else begin
            border <= border_nxt;
        end
    end
`else
    assign border = 1'b0;
`endif

endmodule

// File: tb/tb_line_buf_ctrl.sv
// tb/tb_line_buf_ctrl.sv - self-checking bench for line_buf_ctrl (8x4 frame)

module tb_line_buf_ctrl;

    localparam int LL      = 8;
    localparam int NL      = 4;
    localparam int WIN_LAT = LL + 3;
    localparam int MAXC    = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic       src_sel;
    logic       busy;
    logic       win_valid;
    logic [9:0] cx;
    logic [8:0] cy;
    logic       border;
    logic       done;
    logic       err;

    always #5 clk = ~clk;

    line_buf_ctrl #(
        .LINE_LEN (LL),
        .NUM_LINES(NL),
        .CX_W     (10),
        .CY_W     (9)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .src_sel  (src_sel),
        .busy     (busy),
        .win_valid(win_valid),
        .cx       (cx),
        .cy       (cy),
        .border   (border),
        .done     (done),
        .err      (err)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    function automatic void chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Control-output checkpoints for a nominal frame started at cycle 0.
    // ctl = {in_ready, src_sel, busy, win_valid, done, err}
    typedef struct {
        int         cyc;
        logic [5:0] ctl;
        int         ecx;
        int         ecy;
    } vec_t;

    vec_t vtab[12];

    // Scoreboard entry: one per accepted pixel
    typedef struct {
        int cyc;
        int ecx;
        int ecy;
        int ebord;
    } exp_t;

    exp_t sb[$];

    logic st_v[MAXC];
    logic iv_v[MAXC];
    logic rs_v[MAXC];

    int ir_cnt, ir_first, ir_last;
    int wv_cnt, wv_first, wv_last;
    int done_cnt, done_cyc, err_cnt, err_cyc;
    int busy_cnt, flush_cnt;
    int snap_cyc, snap_cx, snap_cy;
    logic [6:0] snap;

    function automatic int bord_model(input int x, input int y);
`ifdef LINE_BUF_CTRL_BORDER_EN
        return (x == 0 || x == LL - 1 || y == 0 || y == NL - 1) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    task automatic clear_stim();
        for (int i = 0; i < MAXC; i++) begin
            st_v[i] = 1'b0;
            iv_v[i] = 1'b1;
            rs_v[i] = 1'b0;
        end
        st_v[0] = 1'b1;
        snap_cyc = -1;
    endtask

    // Runs ncyc cycles from the current IDLE state; cycle 0 carries the start.
    task automatic run(input int ncyc, input bit use_tab);
        int k;
        exp_t e;
        k = 0;
        ir_cnt = 0; ir_first = -1; ir_last = -1;
        wv_cnt = 0; wv_first = -1; wv_last = -1;
        done_cnt = 0; done_cyc = -1; err_cnt = 0; err_cyc = -1;
        busy_cnt = 0; flush_cnt = 0;
        sb.delete();
        for (int c = 0; c < ncyc; c++) begin
            start    = st_v[c];
            in_valid = iv_v[c];
            rst      = rs_v[c];
            @(negedge clk);
            if (rst) sb.delete();
            if (use_tab) begin
                for (int i = 0; i < 12; i++) begin
                    if (vtab[i].cyc == c) begin
                        chk($sformatf("tab_ctl_c%0d", c),
                            int'({in_ready, src_sel, busy, win_valid, done, err}),
                            int'(vtab[i].ctl));
                        chk($sformatf("tab_cx_c%0d", c), int'(cx), vtab[i].ecx);
                        chk($sformatf("tab_cy_c%0d", c), int'(cy), vtab[i].ecy);
                    end
                end
            end
            if (c == snap_cyc) begin
                snap    = {in_ready, src_sel, busy, win_valid, border, done, err};
                snap_cx = int'(cx);
                snap_cy = int'(cy);
            end
            if (in_ready) begin
                ir_cnt++;
                if (ir_first < 0) ir_first = c;
                ir_last = c;
            end
            if (busy) busy_cnt++;
            if (busy && !in_ready && !done) flush_cnt++;
            if (done) begin done_cnt++; done_cyc = c; end
            if (err) begin err_cnt++; err_cyc = c; end
            if (in_ready && in_valid && !rst) begin
                sb.push_back('{c + WIN_LAT, k % LL, k / LL, bord_model(k % LL, k / LL)});
                k++;
            end
            if (win_valid) begin
                wv_cnt++;
                if (wv_first < 0) wv_first = c;
                wv_last = c;
                if (sb.size() == 0) begin
                    chk($sformatf("wv_unexpected_c%0d", c), 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("wv_cyc_k%0d", k), c, e.cyc);
                    chk($sformatf("wv_cx_c%0d", c), int'(cx), e.ecx);
                    chk($sformatf("wv_cy_c%0d", c), int'(cy), e.ecy);
                    chk($sformatf("wv_border_c%0d", c), int'(border), e.ebord);
                end
            end else begin
                chk($sformatf("idle_coord_c%0d", c), int'({cx, cy, border}), 0);
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        vtab[0]  = '{0,  6'b010000, 0, 0};
        vtab[1]  = '{1,  6'b101000, 0, 0};
        vtab[2]  = '{11, 6'b101000, 0, 0};
        vtab[3]  = '{12, 6'b101100, 0, 0};
        vtab[4]  = '{19, 6'b101100, 7, 0};
        vtab[5]  = '{20, 6'b101100, 0, 1};
        vtab[6]  = '{32, 6'b101100, 4, 2};
        vtab[7]  = '{33, 6'b011100, 5, 2};
        vtab[8]  = '{42, 6'b011100, 6, 3};
        vtab[9]  = '{43, 6'b011110, 7, 3};
        vtab[10] = '{44, 6'b010000, 0, 0};
        vtab[11] = '{45, 6'b010000, 0, 0};

        // Power-on reset
        rst = 1'b1; start = 1'b1; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("reset_ctl", int'({in_ready, src_sel, busy, win_valid, border, done, err}),
            int'(7'b0100000));
        chk("reset_cxcy", int'({cx, cy}), 0);
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        chk("no_start_stays_idle", int'(busy), 0);

        // Nominal frame, with ignored start pulses in RUN (5) and DONE (43)
        clear_stim();
        st_v[5] = 1'b1;
        st_v[43] = 1'b1;
        run(50, 1'b1);
        chk("nom_ir_cnt", ir_cnt, 32);
        chk("nom_ir_first", ir_first, 1);
        chk("nom_ir_last", ir_last, 32);
        chk("nom_flush_cnt", flush_cnt, WIN_LAT - 1);
        chk("nom_wv_cnt", wv_cnt, 32);
        chk("nom_wv_first", wv_first, 12);
        chk("nom_wv_last", wv_last, 43);
        chk("nom_done_cnt", done_cnt, 1);
        chk("nom_done_cyc", done_cyc, 43);
        chk("nom_err_cnt", err_cnt, 0);
        chk("nom_busy_cnt", busy_cnt, 43);
        chk("nom_sb_empty", sb.size(), 0);

        // Underrun at cycle 10
        clear_stim();
        iv_v[10] = 1'b0;
        snap_cyc = 11;
        run(30, 1'b0);
        chk("ur_err_cnt", err_cnt, 1);
        chk("ur_err_cyc", err_cyc, 11);
        chk("ur_state_c11", int'(snap), int'(7'b0100001));
        chk("ur_wv_cnt", wv_cnt, 0);
        chk("ur_done_cnt", done_cnt, 0);
        chk("ur_ir_cnt", ir_cnt, 10);

        // Reset mid-RUN at cycle 20; no resume afterwards
        clear_stim();
        rs_v[20] = 1'b1;
        snap_cyc = 20;
        run(40, 1'b0);
        chk("rr_snap_ctl", int'(snap), int'(7'b0100000));
        chk("rr_snap_cxcy", snap_cx + snap_cy, 0);
        chk("rr_busy_cnt", busy_cnt, 19);
        chk("rr_wv_cnt", wv_cnt, 8);
        chk("rr_wv_last", wv_last, 19);
        chk("rr_done_cnt", done_cnt, 0);
        chk("rr_err_cnt", err_cnt, 0);

        // Reset mid-FLUSH at cycle 38
        clear_stim();
        rs_v[38] = 1'b1;
        snap_cyc = 38;
        run(50, 1'b0);
        chk("fr_snap_ctl", int'(snap), int'(7'b0100000));
        chk("fr_wv_cnt", wv_cnt, 26);
        chk("fr_done_cnt", done_cnt, 0);
        chk("fr_busy_cnt", busy_cnt, 37);

        // Fresh start after reset gives a full-length frame
        clear_stim();
        run(50, 1'b1);
        chk("re_wv_cnt", wv_cnt, 32);
        chk("re_done_cyc", done_cyc, 43);
        chk("re_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
